mem_wb_stage: RTL

- MEM/WB pipeline register plus write-back formatting for the 5-stage pipeline.
- Captures the MEM-stage outputs: control bits, read_data, alu_result and destination register.
- Performs load byte/half extraction with sign or zero extension and drives the single register-file write port.
- Exports registered write-back info for forwarding, a misaligned-load flag and a retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 34 +++
 rtl/mem_wb_stage.sv | 77 +++++++
 2 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bundle. The MEM side drives the instruction fields and the WB side returns
// the registered write-back state. Latency and backpressure are defined by mem_wb_stage.
interface mem_wb_stage_if #(
  parameter int CNT_W = 32
);
  logic             valid_in;
  logic             stall;
  logic             flush;
  logic             MemtoReg_in;
  logic             RegWrite_in;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic [31:0]      read_data;
  logic [31:0]      alu_result;
  logic [4:0]       write_reg_in;
  logic             wb_reg_write;
  logic [4:0]       wb_write_reg;
  logic [31:0]      wb_write_data;
  logic             wb_valid;
  logic             wb_misalign;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output valid_in, stall, flush, MemtoReg_in, RegWrite_in, mem_size, mem_unsigned,
           read_data, alu_result, write_reg_in,
    input  wb_reg_write, wb_write_reg, wb_write_data, wb_valid, wb_misalign, retire_count
  );

  modport slave (
    input  valid_in, stall, flush, MemtoReg_in, RegWrite_in, mem_size, mem_unsigned,
           read_data, alu_result, write_reg_in,
    output wb_reg_write, wb_write_reg, wb_write_data, wb_valid, wb_misalign, retire_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB register with load lane extraction, misalign detection and a saturating retire counter.
// The stage has one cycle of latency and all outputs are registered. Stall holds the stage and flush inserts a bubble.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave mw
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        misaligned;
  logic        reg_write_nxt;
  logic [31:0] data_nxt;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    misaligned = 1'b0;
    byte_lane  = mw.read_data[7:0];
    half_lane  = mw.read_data[15:0];
    data_nxt   = mw.alu_result;

    case (mw.alu_result[1:0])
      2'b00:   byte_lane = mw.read_data[7:0];
      2'b01:   byte_lane = mw.read_data[15:8];
      2'b10:   byte_lane = mw.read_data[23:16];
      default: byte_lane = mw.read_data[31:24];
    endcase
    half_lane = mw.alu_result[1] ? mw.read_data[31:16] : mw.read_data[15:0];

    // Size 2'b11 is decoded as a word access.
    case (mw.mem_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mw.alu_result[0];
      default: misaligned = (mw.alu_result[1:0] != 2'b00);
    endcase
    misaligned = misaligned & mw.MemtoReg_in & mw.valid_in;

    if (mw.MemtoReg_in) begin
      case (mw.mem_size)
        2'b00:   data_nxt = {{24{byte_lane[7] & ~mw.mem_unsigned}}, byte_lane};
        2'b01:   data_nxt = {{16{half_lane[15] & ~mw.mem_unsigned}}, half_lane};
        default: data_nxt = mw.read_data;
      endcase
    end

    reg_write_nxt = mw.valid_in & mw.RegWrite_in & (mw.write_reg_in != 5'd0) & ~misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mw.wb_valid      <= 1'b0;
      mw.wb_reg_write  <= 1'b0;
      mw.wb_misalign   <= 1'b0;
      mw.wb_write_reg  <= 5'd0;
      mw.wb_write_data <= 32'd0;
      mw.retire_count  <= '0;
    end else if (mw.flush) begin
      mw.wb_valid     <= 1'b0;
      mw.wb_reg_write <= 1'b0;
      mw.wb_misalign  <= 1'b0;
    end else if (mw.stall) begin
      // A held misalign flag would repeat, so the pulse is cleared while the stage is stalled.
      mw.wb_misalign <= 1'b0;
    end else begin
      mw.wb_valid      <= mw.valid_in;
      mw.wb_reg_write  <= reg_write_nxt;
      mw.wb_misalign   <= misaligned;
      mw.wb_write_reg  <= mw.write_reg_in;
      mw.wb_write_data <= data_nxt;
      if (mw.valid_in && !misaligned && (mw.retire_count != CNT_MAX))
        mw.retire_count <= mw.retire_count + CNT_ONE;
    end
  end
endmodule
